// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
//   state_t   : frame FSM states (IDLE, COMPARE, DONE)
//   dec_t     : running MSB-first decision (EQ, GT, LT)
//   cnt_width : width of a counter that must hold values up to w
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } dec_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_bit_cmp.sv
// One-bit MSB-first decision cell.
//   dec      : current decision register value
//   a_bit    : current bit of operand A
//   b_bit    : current bit of operand B
//   en       : a bit is being accepted this cycle
//   dec_next : decision after this bit
// Only an undecided (EQ) frame can change; the first differing bit
// seen MSB first fixes the result for the rest of the frame.
module serial_bit_cmp
  import serial_cmp_pkg::*;
(
  input  dec_t dec,
  input  logic a_bit,
  input  logic b_bit,
  input  logic en,
  output dec_t dec_next
);

  always_comb begin
    dec_next = dec;
    if (en && (dec == EQ)) begin
      if (a_bit && !b_bit) begin
        dec_next = GT;
      end else if (!a_bit && b_bit) begin
        dec_next = LT;
      end
    end
  end

endmodule

// File: rtl/serial_eq_comp.sv
// Bit-serial unsigned comparator. Operands A and B arrive one bit per
// accepted cycle, MSB first, over a frame of WIDTH bits; at the end of
// the frame exactly one of is_equal / a_gt_b / a_lt_b is raised.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : begin (or restart) a frame; sampled every cycle
//   bit_valid : a_bit/b_bit carry a bit this cycle
//   a_bit     : operand A bit, MSB first
//   b_bit     : operand B bit, MSB first
//   busy      : frame in progress (state COMPARE)
//   done      : one-cycle pulse, result valid
//   is_equal  : A == B for the last completed frame
//   a_gt_b    : A >  B for the last completed frame
//   a_lt_b    : A <  B for the last completed frame
//
// Handshake: a bit is accepted on a rising edge when the FSM is in
// COMPARE, bit_valid=1 and start=0. There is no backpressure; the
// source may leave gaps (bit_valid=0) of any length. start always wins
// over bit_valid, so the bit offered with start is dropped. All outputs
// are registered; results read 0 from the start edge until done.
module serial_eq_comp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic is_equal,
  output logic a_gt_b,
  output logic a_lt_b
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  dec_t             dec;
  dec_t             dec_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (state == COMPARE) && bit_valid && !start;

  serial_bit_cmp u_bit_cmp (
    .dec      (dec),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .en       (accept),
    .dec_next (dec_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dec      <= EQ;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_equal <= 1'b0;
      a_gt_b   <= 1'b0;
      a_lt_b   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= COMPARE;
            dec      <= EQ;
            cnt      <= '0;
            busy     <= 1'b1;
            is_equal <= 1'b0;
            a_gt_b   <= 1'b0;
            a_lt_b   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        COMPARE: begin
          if (start) begin
            // Restart: drop everything gathered so far, no done pulse.
            dec <= EQ;
            cnt <= '0;
          end else if (bit_valid) begin
            dec <= dec_next;
            if (cnt == LAST) begin
              // Last bit: results load together with the done pulse.
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              is_equal <= (dec_next == EQ);
              a_gt_b   <= (dec_next == GT);
              a_lt_b   <= (dec_next == LT);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_eq_comp.sv
module tb_serial_eq_comp;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;
  logic busy, done, is_equal, a_gt_b, a_lt_b;

  int tests = 0;
  int errors = 0;

  // Expected {is_equal, a_gt_b, a_lt_b} per completed frame.
  logic [2:0] exp_q[$];
  logic [2:0] last_res = 3'b000;

  serial_eq_comp #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .is_equal  (is_equal),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned comparison of the whole operands.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a == b, a > b, a < b};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      last_res = 3'b000;
      check("reset_outputs", {busy, done, is_equal, a_gt_b, a_lt_b}, 0);
    end else if (done) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending frame at %0t", $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check("result", {is_equal, a_gt_b, a_lt_b}, e);
        check("busy_at_done", busy, 0);
        last_res = e;
      end
    end else if (busy) begin
      check("result_zero_busy", {is_equal, a_gt_b, a_lt_b}, 0);
    end else begin
      check("result_held", {is_equal, a_gt_b, a_lt_b}, last_res);
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs starting just after a rising edge.
  task automatic cycle(input logic st, input logic bv, input logic a, input logic b);
    start = st;
    bit_valid = bv;
    a_bit = a;
    b_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cycle();
    // Offered bit with start must be dropped, so randomize it.
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("busy_stall", busy, 1);
    end
  endtask

  // Full frame: start, then W bits MSB first with gaps.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int gap_max, input int fix_k, input int fix_len);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = a;
    bv = b;
    start_cycle();
    check("busy_after_start", busy, 1);
    for (int k = 0; k < W; k++) begin
      gap((k == fix_k) ? fix_len : $urandom_range(0, gap_max));
      if (k == W - 1) exp_q.push_back(ref_cmp(av, bv));
      cycle(1'b0, 1'b1, av[W-1-k], bv[W-1-k]);
    end
    check("done_latency", done, 1);
  endtask

  // Start a frame and feed n < W bits, leaving it unfinished.
  task automatic partial_frame(input int n);
    start_cycle();
    for (int k = 0; k < n; k++) begin
      gap($urandom_range(0, 1));
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("idle_not_busy", busy, 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset
    #12;
    check("reset_state", {busy, done, is_equal, a_gt_b, a_lt_b}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Equal operands
    send_frame(4'd13, 4'd13, 0, -1, 0);
    idle(2);
    check("eq_held", {is_equal, a_gt_b, a_lt_b}, 3'b100);

    // Decided at MSB
    send_frame(4'd4, 4'd14, 0, -1, 0);
    idle(1);

    // Stall of 3 cycles between bits 2 and 3
    send_frame(4'd1, 4'd0, 0, 2, 3);
    idle(1);

    // Restart mid-frame, only the second frame completes
    partial_frame(2);
    send_frame(4'd7, 4'd7, 0, -1, 0);
    idle(1);

    // Asynchronous reset mid-frame, between edges
    partial_frame(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, is_equal, a_gt_b, a_lt_b}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("ignore_bits_idle", {busy, done}, 0);
    end

    // start in the DONE cycle
    send_frame(4'd9, 4'd9, 0, -1, 0);
    send_frame(4'd0, 4'd1, 0, -1, 0);
    idle(1);

    // Randomized frames: gaps, restarts, back-to-back starts
    for (int f = 0; f < 60; f++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 4) == 0) partial_frame($urandom_range(0, W - 1));
      send_frame(ra, rb, 2, -1, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
